// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind a UART receiver: hunts for a sync byte, collects
// CMD/LEN/payload/CHK, verifies the XOR checksum, then drains the buffered
// payload through a valid/ready port. Errors are reported as one-cycle pulses.
module uart_rx_pkt_ctrl #(
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_CLKS = 8680,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Pkt_Valid,
   output logic [7:0] o_Cmd,
   output logic [7:0] o_Len,
   output logic       o_Pay_Valid,
   input  logic       i_Pay_Ready,
   output logic [7:0] o_Pay_Byte,
   output logic       o_Pay_Last,
   output logic       o_Err,
   output logic [1:0] o_Err_Code
);

   localparam int unsigned IdxW     = $clog2(MAX_LEN + 1);
   localparam int unsigned CntW     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   // Power-of-two depth so the index width addresses the array exactly.
   localparam int unsigned BufDepth = 1 << IdxW;

   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]      MaxLenB = 8'(MAX_LEN);

   localparam logic [1:0] ErrOverrun  = 2'b00;
   localparam logic [1:0] ErrChecksum = 2'b01;
   localparam logic [1:0] ErrLength   = 2'b10;
   localparam logic [1:0] ErrTimeout  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StLen,
      StPayload,
      StChk,
      StDrain
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        xor_q, xor_d;
   logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
   logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [7:0]        out_cmd_q, out_cmd_d;
   logic [7:0]        out_len_q, out_len_d;
   logic              pay_valid_q, pay_valid_d;
   logic [7:0]        pay_byte_q, pay_byte_d;
   logic              pay_last_q, pay_last_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;

   logic [7:0]        buf_q [BufDepth];
   logic              buf_we;
   logic [IdxW-1:0]   rd_next;
   logic              in_frame;

   // Next-state, datapath and output computation.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      xor_d       = xor_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      cnt_d       = cnt_q;
      pkt_valid_d = 1'b0;
      out_cmd_d   = out_cmd_q;
      out_len_d   = out_len_q;
      pay_valid_d = pay_valid_q;
      pay_byte_d  = pay_byte_q;
      pay_last_d  = pay_last_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      buf_we      = 1'b0;
      rd_next     = rd_idx_q + IdxW'(1);
      in_frame    = (state_q == StCmd) || (state_q == StLen) ||
                    (state_q == StPayload) || (state_q == StChk);

      // Inter-byte gap counter only runs while a frame is being collected.
      if (i_Rx_DV || !in_frame) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (i_Rx_DV) begin
               cmd_d   = i_Rx_Byte;
               xor_d   = i_Rx_Byte;
               state_d = StLen;
            end
         end
         StLen: begin
            if (i_Rx_DV) begin
               len_d = i_Rx_Byte;
               xor_d = xor_q ^ i_Rx_Byte;
               if (i_Rx_Byte > MaxLenB) begin
                  err_d      = 1'b1;
                  err_code_d = ErrLength;
                  state_d    = StIdle;
               end else if (i_Rx_Byte == 8'd0) begin
                  state_d = StChk;
               end else begin
                  wr_idx_d = '0;
                  state_d  = StPayload;
               end
            end
         end
         StPayload: begin
            if (i_Rx_DV) begin
               buf_we   = 1'b1;
               xor_d    = xor_q ^ i_Rx_Byte;
               wr_idx_d = wr_idx_q + IdxW'(1);
               if (8'(wr_idx_q) == (len_q - 8'd1)) begin
                  state_d = StChk;
               end
            end
         end
         StChk: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte != xor_q) begin
                  err_d      = 1'b1;
                  err_code_d = ErrChecksum;
                  state_d    = StIdle;
               end else begin
                  pkt_valid_d = 1'b1;
                  out_cmd_d   = cmd_q;
                  out_len_d   = len_q;
                  rd_idx_d    = '0;
                  state_d     = (len_q != 8'd0) ? StDrain : StIdle;
               end
            end
         end
         StDrain: begin
            // Bytes arriving while draining are dropped; the drain is unaffected.
            if (i_Rx_DV) begin
               err_d      = 1'b1;
               err_code_d = ErrOverrun;
            end
            if (!pay_valid_q) begin
               // First cycle in drain: present buffer[0].
               pay_valid_d = 1'b1;
               pay_byte_d  = buf_q[rd_idx_q];
               pay_last_d  = (8'(rd_idx_q) == (len_q - 8'd1));
            end else if (i_Pay_Ready) begin
               if (pay_last_q) begin
                  pay_valid_d = 1'b0;
                  pay_last_d  = 1'b0;
                  state_d     = StIdle;
               end else begin
                  rd_idx_d   = rd_next;
                  pay_byte_d = buf_q[rd_next];
                  pay_last_d = (8'(rd_next) == (len_q - 8'd1));
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A byte on the expiry cycle wins over the timeout.
      if (in_frame && !i_Rx_DV && (cnt_q == CntMax)) begin
         err_d      = 1'b1;
         err_code_d = ErrTimeout;
         state_d    = StIdle;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= StIdle;
         cmd_q       <= '0;
         len_q       <= '0;
         xor_q       <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         cnt_q       <= '0;
         pkt_valid_q <= 1'b0;
         out_cmd_q   <= '0;
         out_len_q   <= '0;
         pay_valid_q <= 1'b0;
         pay_byte_q  <= '0;
         pay_last_q  <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         xor_q       <= xor_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         cnt_q       <= cnt_d;
         pkt_valid_q <= pkt_valid_d;
         out_cmd_q   <= out_cmd_d;
         out_len_q   <= out_len_d;
         pay_valid_q <= pay_valid_d;
         pay_byte_q  <= pay_byte_d;
         pay_last_q  <= pay_last_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   // Payload buffer; contents are don't-care after reset.
   always_ff @(posedge i_Clock) begin
      if (buf_we) begin
         buf_q[wr_idx_q] <= i_Rx_Byte;
      end
   end

   assign o_Pkt_Valid = pkt_valid_q;
   assign o_Cmd       = out_cmd_q;
   assign o_Len       = out_len_q;
   assign o_Pay_Valid = pay_valid_q;
   assign o_Pay_Byte  = pay_byte_q;
   assign o_Pay_Last  = pay_last_q;
   assign o_Err       = err_q;
   assign o_Err_Code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: stimulus pushes expected packet,
// error and payload events into queues; a monitor pops and compares.
module tb_uart_rx_pkt_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       pay_ready = 1'b1;

   logic       pkt_valid;
   logic [7:0] cmd;
   logic [7:0] len;
   logic       pay_valid;
   logic [7:0] pay_byte;
   logic       pay_last;
   logic       err;
   logic [1:0] err_code;

   uart_rx_pkt_ctrl #(
      .MAX_LEN      (16),
      .TIMEOUT_CLKS (8680),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Rx_DV     (rx_dv),
      .i_Rx_Byte   (rx_byte),
      .o_Pkt_Valid (pkt_valid),
      .o_Cmd       (cmd),
      .o_Len       (len),
      .o_Pay_Valid (pay_valid),
      .i_Pay_Ready (pay_ready),
      .o_Pay_Byte  (pay_byte),
      .o_Pay_Last  (pay_last),
      .o_Err       (err),
      .o_Err_Code  (err_code)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected events: {cmd,len}, error code, {last,byte}.
   logic [15:0] pkt_q [$];
   logic [1:0]  err_q [$];
   logic [8:0]  pay_q [$];

   logic       stall_prev = 1'b0;
   logic [7:0] stall_byte = 8'h00;
   logic       pkt_prev = 1'b0;
   logic [7:0] pkt_prev_len = 8'h00;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
         pkt_prev   <= 1'b0;
      end else begin
         if (pkt_prev) check("pay_valid_after_pkt", 32'(pay_valid), 32'(pkt_prev_len != 8'd0));
         pkt_prev <= 1'b0;
         if (stall_prev) begin
            check("stall_valid", 32'(pay_valid), 32'd1);
            check("stall_byte", 32'(pay_byte), 32'(stall_byte));
         end
         if (pkt_valid || err) check("pkt_err_exclusive", 32'(pkt_valid && err), 32'd0);
         if (pkt_valid) begin
            if (pkt_q.size() == 0) begin
               check("pkt_unexpected", 32'(pkt_valid), 32'd0);
            end else begin
               check("pkt_cmd", 32'(cmd), 32'(pkt_q[0][15:8]));
               check("pkt_len", 32'(len), 32'(pkt_q[0][7:0]));
               pkt_prev     <= 1'b1;
               pkt_prev_len <= pkt_q[0][7:0];
               void'(pkt_q.pop_front());
            end
         end
         if (err) begin
            if (err_q.size() == 0) begin
               check("err_unexpected", 32'(err), 32'd0);
            end else begin
               check("err_code", 32'(err_code), 32'(err_q[0]));
               void'(err_q.pop_front());
            end
         end
         if (pay_valid && pay_ready) begin
            if (pay_q.size() == 0) begin
               check("pay_unexpected", 32'(pay_valid), 32'd0);
            end else begin
               check("pay_byte", 32'(pay_byte), 32'(pay_q[0][7:0]));
               check("pay_last", 32'(pay_last), 32'(pay_q[0][8]));
               void'(pay_q.pop_front());
            end
         end
         stall_prev <= pay_valid && !pay_ready;
         stall_byte <= pay_byte;
      end
   end

   // Drive one byte; consumed on the next rising edge, no trailing gap.
   task automatic send_raw(input logic [7:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      send_raw(b);
      idle(2);
   endtask

   // Frame A5 10 03 11 22 33 CHK; the correct checksum is 10^03^11^22^33 = 13.
   task automatic send_frame(input logic [7:0] chk);
      send(8'hA5);
      send(8'h10);
      send(8'h03);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(chk);
   endtask

   task automatic expect_good_frame(input logic with_payload);
      pkt_q.push_back({8'h10, 8'h03});
      if (with_payload) begin
         pay_q.push_back({1'b0, 8'h11});
         pay_q.push_back({1'b0, 8'h22});
         pay_q.push_back({1'b1, 8'h33});
      end
   endtask

   task automatic wait_empty(input int budget, input string name);
      int n = 0;
      while ((pkt_q.size() + err_q.size() + pay_q.size()) != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(pkt_q.size() + err_q.size() + pay_q.size()), 32'd0);
      idle(4);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
      check({name, "_cmd"}, 32'(cmd), 32'd0);
      check({name, "_len"}, 32'(len), 32'd0);
      check({name, "_pay_valid"}, 32'(pay_valid), 32'd0);
      check({name, "_pay_byte"}, 32'(pay_byte), 32'd0);
      check({name, "_pay_last"}, 32'(pay_last), 32'd0);
      check({name, "_err"}, 32'(err), 32'd0);
      check({name, "_err_code"}, 32'(err_code), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      idle(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      // Good frame with three payload bytes
      expect_good_frame(1'b1);
      send_frame(8'h13);
      wait_empty(100, "good_frame_done");

      // Bad checksum: error only, then a good frame is accepted
      err_q.push_back(2'b01);
      send_frame(8'h00);
      wait_empty(100, "bad_chk_done");
      expect_good_frame(1'b1);
      send_frame(8'h13);
      wait_empty(100, "after_bad_chk_done");

      // Over-length: error, trailing bytes ignored until the next sync
      err_q.push_back(2'b10);
      send(8'hA5);
      send(8'h01);
      send(8'h11);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h10);
      wait_empty(100, "len_err_done");
      expect_good_frame(1'b1);
      send_frame(8'h13);
      wait_empty(100, "after_len_err_done");
      check("err_code_held", 32'(err_code), 32'h2);

      // Timeout after LEN-state silence, reported exactly once
      err_q.push_back(2'b11);
      send(8'hA5);
      send(8'h02);
      wait_empty(9000, "timeout_done");
      idle(100);

      // Byte arriving on the expiry cycle is accepted, no timeout
      pkt_q.push_back({8'h02, 8'h00});
      send_raw(8'hA5);
      send_raw(8'h02);
      idle(8679);
      send_raw(8'h00);
      idle(2);
      send(8'h02);
      wait_empty(100, "expiry_edge_done");
      check("err_code_after_expiry", 32'(err_code), 32'h3);

      // Stalled drain with an overrun byte
      pay_ready = 1'b0;
      expect_good_frame(1'b1);
      err_q.push_back(2'b00);
      send_frame(8'h13);
      send(8'hA5);
      idle(50);
      check("stalled_pay_valid", 32'(pay_valid), 32'd1);
      check("stalled_pay_byte", 32'(pay_byte), 32'h11);
      pay_ready = 1'b1;
      wait_empty(100, "overrun_done");
      check("err_code_overrun_held", 32'(err_code), 32'h0);

      // Zero-length packet after leading noise
      pkt_q.push_back({8'h07, 8'h00});
      send(8'h00);
      send(8'hFF);
      send(8'hA5);
      send(8'h07);
      send(8'h00);
      send(8'h07);
      wait_empty(100, "zero_len_done");
      check("zero_len_cmd_held", 32'(cmd), 32'h07);

      // Reset mid-payload: immediate clear, no error
      send(8'hA5);
      send(8'h10);
      send(8'h03);
      send(8'h11);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_payload");
      idle(2);
      rst_n = 1'b1;
      idle(2);
      expect_good_frame(1'b1);
      send_frame(8'h13);
      wait_empty(100, "after_reset_payload_done");

      // Reset mid-drain: remaining payload discarded
      pay_ready = 1'b0;
      expect_good_frame(1'b0);
      send_frame(8'h13);
      idle(5);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_drain");
      idle(2);
      rst_n = 1'b1;
      pay_ready = 1'b1;
      idle(10);
      expect_good_frame(1'b1);
      send_frame(8'h13);
      wait_empty(100, "after_reset_drain_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
